// File: rtl/wb_rrarb.sv
// wb_rrarb: 4-master round-robin Wishbone arbiter for one shared slave; define WB_RRARB_TIMEOUT_EN for the stall timeout
module wb_rrarb #(
  parameter int TIMEOUT = 1023
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic [3:0]   m_cyc_i,
  input  logic [3:0]   m_stb_i,
  input  logic [3:0]   m_we_i,
  input  logic [127:0] m_adr_i,
  input  logic [127:0] m_dat_i,
  input  logic [15:0]  m_sel_i,
  input  logic [11:0]  m_cti_i,
  output logic [31:0]  m_dat_o,
  output logic [3:0]   m_ack_o,
  output logic [3:0]   m_err_o,
  output logic         s_cyc_o,
  output logic         s_stb_o,
  output logic         s_we_o,
  output logic [31:0]  s_adr_o,
  output logic [31:0]  s_dat_o,
  output logic [3:0]   s_sel_o,
  output logic [2:0]   s_cti_o,
  input  logic [31:0]  s_dat_i,
  input  logic         s_ack_i,
  output logic [1:0]   gnt_o,
  output logic         busy_o
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [1:0] gnt, last, win;
  logic tmo;
  // first requester after the previous owner, wrapping round to the previous owner itself
  always_comb begin
    win = last;
    for (int i = 3; i >= 0; i--) win = m_cyc_i[last + 2'(i + 1)] ? last + 2'(i + 1) : win;
  end
  // arbitrate only from IDLE and hold the grant until the owner drops cyc
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= 2'd3;
    end else if (state == IDLE) begin
      if (|m_cyc_i) begin
        state <= GRANT;
        gnt   <= win;
      end
    end else if (!m_cyc_i[gnt]) begin
      state <= IDLE;
      last  <= gnt;
    end
  end
  assign busy_o  = state == GRANT;
  assign gnt_o   = gnt;
  assign s_cyc_o = busy_o & m_cyc_i[gnt];
  assign s_stb_o = busy_o & m_stb_i[gnt] & ~tmo;
  assign s_we_o  = m_we_i[gnt];
  assign s_adr_o = m_adr_i[{gnt, 5'd0} +: 32];
  assign s_dat_o = m_dat_i[{gnt, 5'd0} +: 32];
  assign s_sel_o = m_sel_i[{gnt, 2'd0} +: 4];
  assign s_cti_o = m_cti_i[3 * gnt +: 3];
  assign m_dat_o = s_dat_i;
  assign m_ack_o = (busy_o & s_ack_i) ? 4'b0001 << gnt : 4'b0000;
`ifdef WB_RRARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign tmo     = busy_o && cnt == CW'(TIMEOUT);
  assign m_err_o = tmo ? 4'b0001 << gnt : 4'b0000;
  // run length of the owner's unacknowledged strobes; the timeout cycle drops stb and so restarts it
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) cnt <= '0;
    else cnt <= (!busy_o || s_ack_i || !s_stb_o) ? '0 : cnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign tmo     = 1'b0;
  assign m_err_o = 4'b0000;
`endif
endmodule
